// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader state encoding and the defaults shared with fetch.
package imem_loader_pkg;

    localparam int unsigned MEM_BYTES_DEF = 56;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_OVF   = 3'd4
    } load_state_t;

    // Big-endian byte lane: idx 0 is the MSB.
    function automatic logic [7:0] be_byte(input logic [31:0] w,
                                           input logic [1:0] idx);
        logic [31:0] s;
        s = w << (8 * idx);
        return s[31:24];
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into byte-wide instruction memory,
// MSB first, holding the CPU via busy until HALT_WORD or overflow.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] word_count
);

    // Highest base at which a full word still fits.
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(MEM_BYTES - 4);

    load_state_t       state;
    logic [1:0]        idx;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] count;
    logic [31:0]       word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= 2'd0;
            base  <= '0;
            count <= '0;
            word  <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE, ST_OVF: begin
                    if (start) begin
                        state <= ST_LOAD;
                        base  <= '0;
                        count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        word <= in_data;
                        idx  <= 2'd0;
                        if (base > LAST_BASE) begin
                            state <= ST_OVF;
                        end else begin
                            state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        base  <= base + ADDR_W'(4);
                        count <= count + ADDR_W'(1);
                        state <= (word == HALT_WORD) ? ST_DONE : ST_LOAD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == ST_LOAD);
        busy      = (state == ST_LOAD) || (state == ST_WRITE);
        done      = (state == ST_DONE);
        overflow  = (state == ST_OVF);
        mem_we    = (state == ST_WRITE);
        mem_addr  = base;
        mem_wdata = 8'h00;
        if (state == ST_WRITE) begin
            mem_addr  = base + ADDR_W'(idx);
            mem_wdata = be_byte(word, idx);
        end
    end

    assign word_count = count;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: queue-based write model
// compared every cycle, plus literal checks on memory image.
module tb_imem_loader;

    localparam int          MEM  = 56;
    localparam int          AW   = 32;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data = '0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW-1:0] word_count;

    imem_loader #(
        .MEM_BYTES(MEM),
        .ADDR_W(AW),
        .HALT_WORD(HALT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending byte writes are a queue; a word is
    // four queued writes, and the loader is busy until they drain.
    typedef struct {
        int         addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wq[$];
    bit         m_loading = 0;
    bit         m_done = 0;
    bit         m_ovf = 0;
    bit         m_halt = 0;
    int         m_base = 0;
    int         m_count = 0;
    logic [7:0] mem_model[MEM];
    logic [7:0] dut_mem[MEM];
    bit         armed = 0;
    int         we_cycles = 0;
    int         ready_low = 0;

    always @(posedge clk) begin
        if (reset) begin
            if (wq.size() > 0) mem_model[wq[0].addr] = wq[0].data;
            wq.delete();
            m_loading = 0;
            m_done = 0;
            m_ovf = 0;
            m_halt = 0;
            m_base = 0;
            m_count = 0;
        end else if (wq.size() > 0) begin
            mem_model[wq[0].addr] = wq[0].data;
            void'(wq.pop_front());
            if (wq.size() == 0) begin
                m_base += 4;
                m_count++;
                if (m_halt) begin
                    m_loading = 0;
                    m_done = 1;
                end
            end
        end else if (m_loading) begin
            if (in_valid) begin
                if (m_base + 4 > MEM) begin
                    m_loading = 0;
                    m_ovf = 1;
                end else begin
                    for (int k = 0; k < 4; k++)
                        wq.push_back('{addr: m_base + k,
                                       data: 8'(in_data >> (24 - 8 * k))});
                    m_halt = (in_data == HALT);
                end
            end
        end else if (start) begin
            m_loading = 1;
            m_done = 0;
            m_ovf = 0;
            m_base = 0;
            m_count = 0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (wq.size() > 0) begin
                check("mem_we", {31'b0, mem_we}, 1);
                check("mem_addr", mem_addr, wq[0].addr);
                check("mem_wdata", {24'b0, mem_wdata}, {24'b0, wq[0].data});
            end else begin
                check("mem_we", {31'b0, mem_we}, 0);
                check("mem_addr", mem_addr, m_base);
                check("mem_wdata", {24'b0, mem_wdata}, 0);
            end
            check("in_ready", {31'b0, in_ready}, {31'b0, m_loading && wq.size() == 0});
            check("busy", {31'b0, busy}, {31'b0, m_loading});
            check("done", {31'b0, done}, {31'b0, m_done});
            check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
            check("word_count", word_count, m_count);
            if (mem_we === 1'b1) begin
                we_cycles++;
                if (mem_addr < MEM) dut_mem[mem_addr] = mem_wdata;
            end
            if (in_ready !== 1'b1) ready_low++;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = w;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", {31'b0, in_ready}, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data = $urandom;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        check({tag, "_ready"}, {31'b0, in_ready}, 1);
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h0;
        return w;
    endfunction

    function automatic logic [31:0] dut_word(input int b);
        return {dut_mem[b], dut_mem[b+1], dut_mem[b+2], dut_mem[b+3]};
    endfunction

    logic [31:0] sent[14];
    logic [31:0] wa;
    logic [31:0] wb;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < MEM; i++) begin
            mem_model[i] = 8'h00;
            dut_mem[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        armed = 1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_ready", {31'b0, in_ready}, 0);
        check("rst_we", {31'b0, mem_we}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_count", word_count, 0);

        pulse_start();
        send(32'h0000_0022);
        send(32'h8C01_0000);
        wait_ready("t1");
        check("t1_w0", dut_word(0), 32'h0000_0022);
        check("t1_w1", dut_word(4), 32'h8C01_0000);
        check("t1_count", word_count, 2);
        check("t1_busy", {31'b0, busy}, 1);
        check("t1_done", {31'b0, done}, 0);

        send(HALT);
        repeat (4) @(negedge clk);
        #1;
        check("t2_done", {31'b0, done}, 1);
        check("t2_busy", {31'b0, busy}, 0);
        check("t2_ready", {31'b0, in_ready}, 0);
        check("t2_w2", dut_word(8), 32'hFFFF_FFFF);
        check("t2_count", word_count, 3);
        in_valid = 1'b1;
        in_data = $urandom;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;

        pulse_start();
        #1;
        check("t6_done_clr", {31'b0, done}, 0);
        check("t6_base0", mem_addr, 0);
        check("t6_count0", word_count, 0);

        for (int i = 0; i < 14; i++) begin
            sent[i] = rnd_word();
            send(sent[i]);
        end
        wait_ready("t3");
        check("t3_ovf", {31'b0, overflow}, 0);
        check("t3_count", word_count, 14);
        check("t3_base", mem_addr, 56);
        for (int i = 0; i < 14; i++)
            check($sformatf("t3_word%0d", i), dut_word(4 * i), sent[i]);
        #1;
        we_cycles = 0;
        send(rnd_word());
        repeat (4) @(negedge clk);
        #1;
        check("t3_ovf_set", {31'b0, overflow}, 1);
        check("t3_ovf_count", word_count, 14);
        check("t3_ovf_nowe", we_cycles, 0);
        check("t3_ovf_busy", {31'b0, busy}, 0);

        pulse_start();
        @(negedge clk);
        #1;
        we_cycles = 0;
        ready_low = 0;
        repeat (10) @(negedge clk);
        #1;
        check("t4_idle_we", we_cycles, 0);
        check("t4_idle_ready", ready_low, 0);
        wa = rnd_word();
        send(wa);
        repeat (6) @(negedge clk);
        #1;
        check("t4_we_cycles", we_cycles, 4);
        check("t4_word", dut_word(0), wa);

        send(rnd_word());
        pulse_start();
        wait_ready("t6");
        check("t6_count", word_count, 2);
        check("t6_base", mem_addr, 8);

        send(rnd_word());
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t5_we", {31'b0, mem_we}, 0);
        check("t5_count", word_count, 0);
        check("t5_busy", {31'b0, busy}, 0);
        check("t5_addr", mem_addr, 0);
        pulse_start();
        wa = rnd_word();
        wb = rnd_word();
        send(wa);
        send(wb);
        wait_ready("t5");
        check("t5_w0", dut_word(0), wa);
        check("t5_w1", dut_word(4), wb);

        for (int i = 0; i < MEM; i++)
            check($sformatf("mem_byte%0d", i), {24'b0, dut_mem[i]}, {24'b0, mem_model[i]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
